// File: rtl/input_arbiter_nq_pkg.sv
// input_arbiter_nq_pkg: shared state encoding and width helper for the N-queue input arbiter
package input_arbiter_nq_pkg;
  typedef enum logic {IDLE, WR_PKT} state_t;
  function automatic int log2(input int n);
    int r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/input_arbiter_nq_sel.sv
// input_arbiter_nq_sel: first non-empty queue, rotating from cur_queue or fixed from queue 0
module input_arbiter_nq_sel
  import input_arbiter_nq_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  localparam int QW = log2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] empty,
  input  logic [QW-1:0]         cur_queue,
  input  logic                  mode,
  output logic [QW-1:0]         sel,
  output logic                  sel_valid
);
  function automatic logic [QW-1:0] wrap(input logic [QW-1:0] c, input int i);
    int k = int'(c) + i;
    return QW'(k >= NUM_QUEUES ? k - NUM_QUEUES : k);
  endfunction
  // scan from the farthest candidate down so the nearest non-empty one wins
  always_comb begin
    sel = '0;
    sel_valid = 1'b0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--)
      if (!empty[mode ? QW'(i) : wrap(cur_queue, i)]) begin
        sel = mode ? QW'(i) : wrap(cur_queue, i);
        sel_valid = 1'b1;
      end
  end
endmodule

// File: rtl/small_fifo.sv
// small_fifo: registered-read FIFO, dout valid the cycle after rd_en, nearly_full with one slot spare
module small_fifo #(
  parameter int WIDTH = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty,
  input  logic             reset,
  input  logic             clk
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] rd_ptr, wr_ptr;
  logic [MAX_DEPTH_BITS:0] depth;
  assign empty = depth == '0;
  assign nearly_full = depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  // storage array, left unreset
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  // pointers, occupancy and registered read port
  always_ff @(posedge clk)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      depth <= '0;
      dout <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout <= mem[rd_ptr];
      end
      depth <= depth + (MAX_DEPTH_BITS+1)'(wr_en) - (MAX_DEPTH_BITS+1)'(rd_en);
    end
endmodule

// File: rtl/input_arbiter_nq.sv
// input_arbiter_nq: merges NUM_QUEUES packet streams one whole packet per grant, weighted round-robin or strict priority
module input_arbiter_nq
  import input_arbiter_nq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 4,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int WEIGHT_WIDTH = 4,
  parameter int STAGE_NUMBER = 2,
  localparam int QW = log2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic                             mode,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
  output logic                             pkt_done,
  output logic [QW-1:0]                    pkt_src
);
  state_t state;
  logic [NUM_QUEUES-1:0] empty, nearly_full, rd_en;
  logic [NUM_QUEUES-1:0][CTRL_WIDTH+DATA_WIDTH-1:0] dout;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] cur_word;
  logic [CTRL_WIDTH-1:0] cur_ctrl, ctrl_prev;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [QW-1:0] cur_queue, sel;
  logic [WEIGHT_WIDTH-1:0] burst_cnt, w_sel, burst_load;
  logic sel_valid, fresh, grant, is_eop, wr_word, keep;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_fifo
    small_fifo #(.WIDTH(CTRL_WIDTH + DATA_WIDTH), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
      .din({in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH], in_data[q*DATA_WIDTH +: DATA_WIDTH]}),
      .wr_en(in_wr[q]),
      .rd_en(rd_en[q]),
      .dout(dout[q]),
      .nearly_full(nearly_full[q]),
      .empty(empty[q]),
      .reset(reset),
      .clk(clk)
    );
  end

  input_arbiter_nq_sel #(.NUM_QUEUES(NUM_QUEUES)) u_sel (
    .empty(empty),
    .cur_queue(cur_queue),
    .mode(mode),
    .sel(sel),
    .sel_valid(sel_valid)
  );

  assign in_rdy = ~nearly_full;
  assign cur_word = dout[cur_queue];
  assign cur_ctrl = cur_word[DATA_WIDTH +: CTRL_WIDTH];
  assign cur_data = cur_word[DATA_WIDTH-1:0];
  assign w_sel = weights[sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign burst_load = w_sel - WEIGHT_WIDTH'(w_sel != '0);
  assign grant = state == IDLE && out_rdy && sel_valid;
  assign is_eop = state == WR_PKT && out_rdy && cur_ctrl != '0 && ctrl_prev == '0;
  assign wr_word = state == WR_PKT && out_rdy && !is_eop && !empty[cur_queue];
  assign keep = !mode && burst_cnt != '0 && !empty[cur_queue];
  assign rd_en = (grant || wr_word) ? NUM_QUEUES'(1) << (grant ? sel : cur_queue) : '0;

  // packet FSM with grant bookkeeping and registered output stage
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cur_queue <= '0;
      burst_cnt <= '0;
      fresh <= 1'b1;
      ctrl_prev <= CTRL_WIDTH'(1);
      out_wr <= 1'b0;
      out_ctrl <= CTRL_WIDTH'(1);
      out_data <= '0;
      pkt_done <= 1'b0;
      pkt_src <= '0;
    end else begin
      out_data <= cur_data;
      out_ctrl <= cur_ctrl;
      out_wr <= is_eop || wr_word;
      pkt_done <= is_eop;
      if (is_eop) pkt_src <= cur_queue;
      if (wr_word) ctrl_prev <= cur_ctrl;
      if (grant) begin
        state <= WR_PKT;
        cur_queue <= sel;
        ctrl_prev <= CTRL_WIDTH'(STAGE_NUMBER);
        fresh <= 1'b0;
        if (fresh || sel != cur_queue) burst_cnt <= burst_load;
      end
      if (is_eop) begin
        state <= IDLE;
        burst_cnt <= keep ? burst_cnt - 1'b1 : burst_cnt;
        cur_queue <= keep ? cur_queue : cur_queue == QW'(NUM_QUEUES - 1) ? '0 : cur_queue + 1'b1;
        fresh <= !keep;
      end
    end
endmodule

// File: tb/tb_input_arbiter_nq.sv
// tb_input_arbiter_nq: directed self-checking bench for input_arbiter_nq
module tb_input_arbiter_nq;
  localparam int NQ = 4, DW = 64, CW = 8;
  logic clk = 1'b0, reset = 1'b1, out_rdy = 1'b0, mode = 1'b0;
  logic [NQ*DW-1:0] in_data = '0;
  logic [NQ*CW-1:0] in_ctrl = '0;
  logic [NQ-1:0] in_wr = '0, in_rdy;
  logic [NQ*4-1:0] weights = 16'h1111;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic out_wr, pkt_done, rdy_edge;
  logic [1:0] pkt_src;
  logic [CW+DW-1:0] feed_mem [NQ][128];
  int feed_n [NQ] = '{0, 0, 0, 0};
  int feed_i [NQ] = '{0, 0, 0, 0};
  logic [CW+DW-1:0] out_log [512], exp_mem [256];
  int out_cyc [512], src_log [64], src_cyc [64], exp_src [64];
  int out_n = 0, src_n = 0, cyc = 0, bp_viol = 0, exp_n = 0, exp_sn = 0;
  int checks = 0, errors = 0;

  input_arbiter_nq dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .mode(mode), .weights(weights), .pkt_done(pkt_done), .pkt_src(pkt_src)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [CW+DW-1:0] word(input int q, input int p, input int k, input int len);
    logic [7:0] c = k == 0 ? 8'hFF : k == len - 1 ? 8'h01 : 8'h00;
    return {c, 32'(q), 16'(p), 16'(k)};
  endfunction

  // feeder: pushes queued words into each rx queue whenever it has room
  initial forever begin
    @(negedge clk);
    for (int q = 0; q < NQ; q++) begin
      if (reset) feed_i[q] = feed_n[q];
      if (!reset && in_rdy[q] && feed_i[q] < feed_n[q]) begin
        in_wr[q] = 1'b1;
        in_data[q*DW +: DW] = feed_mem[q][feed_i[q]][DW-1:0];
        in_ctrl[q*CW +: CW] = feed_mem[q][feed_i[q]][DW +: CW];
        feed_i[q]++;
      end else in_wr[q] = 1'b0;
    end
  end

  // monitor: logs emitted words and completed packets
  initial forever begin
    @(posedge clk);
    rdy_edge = out_rdy;
    cyc++;
    #1;
    if (out_wr && out_n < 512) begin
      out_log[out_n] = {out_ctrl, out_data};
      out_cyc[out_n] = cyc;
      out_n++;
      if (!rdy_edge) bp_viol++;
    end
    if (pkt_done && src_n < 64) begin
      src_log[src_n] = int'(pkt_src);
      src_cyc[src_n] = cyc;
      src_n++;
    end
  end

  task automatic check(input string tag, input logic [CW+DW-1:0] obs, input logic [CW+DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int q, input int p, input int len);
    for (int k = 0; k < len; k++) begin
      feed_mem[q][feed_n[q]] = word(q, p, k, len);
      feed_n[q]++;
    end
  endtask

  task automatic expect_pkt(input int q, input int p, input int len);
    for (int k = 0; k < len; k++) begin
      exp_mem[exp_n] = word(q, p, k, len);
      exp_n++;
    end
    exp_src[exp_sn] = q;
    exp_sn++;
  endtask

  task automatic wait_src(input string tag, input int target);
    int t = 0;
    while (src_n < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 72'(src_n), 72'(target));
  endtask

  task automatic check_stream(input string tag, input int bw, input int bs);
    check({tag, "_nwords"}, 72'(out_n - bw), 72'(exp_n));
    for (int i = 0; i < exp_n; i++) check($sformatf("%s_w%0d", tag, i), out_log[bw + i], exp_mem[i]);
    for (int i = 0; i < exp_sn; i++) check($sformatf("%s_src%0d", tag, i), 72'(src_log[bs + i]), 72'(exp_src[i]));
    exp_n = 0;
    exp_sn = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int bw, bs, g, t;
    logic [3:0] pat;
    pat = 4'b1001;
    repeat (3) @(negedge clk);
    check("rst_out_wr", 72'(out_wr), 72'(0));
    check("rst_out_ctrl", 72'(out_ctrl), 72'(1));
    check("rst_out_data", 72'(out_data), 72'(0));
    check("rst_pkt_done", 72'(pkt_done), 72'(0));
    check("rst_pkt_src", 72'(pkt_src), 72'(0));
    check("rst_in_rdy", 72'(in_rdy), 72'(4'hF));
    reset = 1'b0;

    add_pkt(2, 0, 5);
    repeat (4) @(negedge clk);
    bw = out_n;
    bs = src_n;
    expect_pkt(2, 0, 5);
    g = cyc;
    out_rdy = 1'b1;
    wait_src("t1_done", bs + 1);
    check_stream("t1", bw, bs);
    check("t1_first_lat", 72'(out_cyc[bw]), 72'(g + 2));
    check("t1_done_cyc", 72'(src_cyc[bs]), 72'(g + 6));

    do_reset();
    weights = 16'h1111;
    for (int q = 0; q < NQ; q++) begin
      add_pkt(q, 1, 3);
      add_pkt(q, 2, 3);
    end
    repeat (6) @(negedge clk);
    bw = out_n;
    bs = src_n;
    for (int r = 1; r <= 2; r++) for (int q = 0; q < NQ; q++) expect_pkt(q, r, 3);
    out_rdy = 1'b1;
    wait_src("t2_done", bs + 8);
    check_stream("t2_rr", bw, bs);

    do_reset();
    weights = 16'h1113;
    for (int p = 1; p <= 6; p++) add_pkt(0, p, 3);
    add_pkt(1, 1, 3);
    add_pkt(1, 2, 3);
    repeat (6) @(negedge clk);
    bw = out_n;
    bs = src_n;
    for (int p = 1; p <= 3; p++) expect_pkt(0, p, 3);
    expect_pkt(1, 1, 3);
    for (int p = 4; p <= 6; p++) expect_pkt(0, p, 3);
    expect_pkt(1, 2, 3);
    out_rdy = 1'b1;
    wait_src("t3_done", bs + 8);
    check_stream("t3_wrr", bw, bs);

    do_reset();
    mode = 1'b1;
    weights = 16'h1111;
    bw = out_n;
    bs = src_n;
    add_pkt(3, 1, 5);
    add_pkt(3, 2, 5);
    out_rdy = 1'b1;
    t = 0;
    while (out_n < bw + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t4_started", 72'(out_n - bw), 72'(2));
    add_pkt(0, 1, 3);
    expect_pkt(3, 1, 5);
    expect_pkt(0, 1, 3);
    expect_pkt(3, 2, 5);
    wait_src("t4_done", bs + 3);
    check_stream("t4_prio", bw, bs);

    do_reset();
    mode = 1'b0;
    add_pkt(1, 1, 5);
    repeat (5) @(negedge clk);
    bw = out_n;
    bs = src_n;
    expect_pkt(1, 1, 5);
    for (int i = 0; i < 40; i++) begin
      out_rdy = pat[i % 4];
      @(negedge clk);
    end
    out_rdy = 1'b1;
    wait_src("t5_done", bs + 1);
    check_stream("t5_bp", bw, bs);
    check("t5_wr_after_stall", 72'(bp_viol), 72'(0));

    do_reset();
    bw = out_n;
    add_pkt(2, 3, 5);
    out_rdy = 1'b1;
    t = 0;
    while (out_n < bw + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_out_wr", 72'(out_wr), 72'(0));
    check("t6_out_ctrl", 72'(out_ctrl), 72'(1));
    check("t6_in_rdy", 72'(in_rdy), 72'(4'hF));
    check("t6_pkt_done", 72'(pkt_done), 72'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_aborted_words", 72'(out_n - bw), 72'(2));
    bw = out_n;
    bs = src_n;
    add_pkt(2, 4, 5);
    expect_pkt(2, 4, 5);
    wait_src("t6_done", bs + 1);
    check_stream("t6_fresh", bw, bs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
